// File: rtl/vending_machine_multi.sv
// Multi-product vending controller with coin credit, a stock counter per product,
// and change paid out one coin per handshake.
module vending_machine_multi #(
    parameter int                           N_PROD     = 4,
    parameter int                           CREDIT_W   = 8,
    parameter logic [N_PROD*CREDIT_W-1:0]   PRICES     = {8'd5, 8'd2, 8'd4, 8'd3},
    parameter int                           MAX_CREDIT = 20,
    parameter int                           INIT_STOCK = 2,
    localparam int                          SEL_W      = (N_PROD > 2) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    input  logic                restock,
    input  logic                chg_ready,
    output logic                vend_valid,
    output logic [SEL_W-1:0]    vend_id,
    output logic                chg_valid,
    output logic [1:0]          chg_coin,
    output logic                coin_reject,
    output logic                sel_nack,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          state,
    output logic [N_PROD-1:0]   sold_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CREDIT = 2'b01,
        S_VEND   = 2'b10,
        S_CHANGE = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] price_q, price_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                coin_reject_d, sel_nack_d, vend_dec;
    logic [3:0]          stock [N_PROD];

    logic [CREDIT_W-1:0] coin_val, price_sel, chg_val;
    logic [3:0]          stock_sel;
    logic                sel_ok, coin_fits;

    function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] c);
        case (c)
            2'b01:   return CREDIT_W'(1);
            2'b10:   return CREDIT_W'(2);
            2'b11:   return CREDIT_W'(4);
            default: return '0;
        endcase
    endfunction

    // Largest coin not exceeding the remaining credit.
    function automatic logic [1:0] change_coin(input logic [CREDIT_W-1:0] cr);
        if (cr >= CREDIT_W'(4))      return 2'b11;
        else if (cr >= CREDIT_W'(2)) return 2'b10;
        else if (cr >= CREDIT_W'(1)) return 2'b01;
        else                         return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        price_d       = price_q;
        sel_d         = sel_q;
        coin_reject_d = 1'b0;
        sel_nack_d    = 1'b0;
        vend_dec      = 1'b0;
        vend_valid    = 1'b0;
        chg_valid     = 1'b0;
        chg_coin      = 2'b00;
        chg_val       = '0;
        sel_ok        = 1'b0;
        price_sel     = '0;
        stock_sel     = '0;

        coin_val  = coin_units(coin);
        coin_fits = ({1'b0, credit_q} + {1'b0, coin_val}) <= (CREDIT_W+1)'(MAX_CREDIT);

        // Lookup by comparison so indices beyond N_PROD never address the tables.
        for (int i = 0; i < N_PROD; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_ok    = 1'b1;
                price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
                stock_sel = stock[i];
            end
        end

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (cancel && state_q == S_CREDIT) begin
                    state_d = S_CHANGE;
                end else if (sel_valid) begin
                    if (state_q == S_CREDIT && sel_ok && stock_sel != 4'd0 &&
                        credit_q >= price_sel) begin
                        state_d = S_VEND;
                        sel_d   = sel;
                        price_d = price_sel;
                    end else begin
                        sel_nack_d = 1'b1;
                    end
                end
                if (coin_valid) begin
                    if (coin != 2'b00 && coin_fits && !sel_valid && !cancel) begin
                        credit_d = credit_q + coin_val;
                        state_d  = S_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                vend_valid    = 1'b1;
                vend_dec      = 1'b1;
                credit_d      = credit_q - price_q;
                state_d       = (credit_q != price_q) ? S_CHANGE : S_IDLE;
                coin_reject_d = coin_valid;
            end
            S_CHANGE: begin
                chg_valid     = 1'b1;
                chg_coin      = change_coin(credit_q);
                chg_val       = coin_units(chg_coin);
                coin_reject_d = coin_valid;
                if (chg_ready) begin
                    credit_d = credit_q - chg_val;
                    if (credit_q == chg_val) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_q    <= '0;
            price_q     <= '0;
            sel_q       <= '0;
            coin_reject <= 1'b0;
            sel_nack    <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            price_q     <= price_d;
            sel_q       <= sel_d;
            coin_reject <= coin_reject_d;
            sel_nack    <= sel_nack_d;
        end
    end

    // Restock overrides a decrement from a vend on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n || restock) begin
            for (int i = 0; i < N_PROD; i++) stock[i] <= 4'(INIT_STOCK);
        end else begin
            for (int i = 0; i < N_PROD; i++) begin
                if (vend_dec && sel_q == SEL_W'(i)) stock[i] <= stock[i] - 4'd1;
            end
        end
    end

    always_comb begin
        sold_out = '0;
        for (int i = 0; i < N_PROD; i++) sold_out[i] = (stock[i] == 4'd0);
    end

    assign vend_id = sel_q;
    assign credit  = credit_q;
    assign state   = state_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scenario bench for vending_machine_multi: tasks drive each scenario, and a
// negedge monitor compares dispensed products and accepted change coins to queues.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       rst_n, coin_valid, sel_valid, cancel, restock, chg_ready;
    logic [1:0] coin, sel;
    logic       vend_valid, chg_valid, coin_reject, sel_nack;
    logic [1:0] vend_id, chg_coin, state;
    logic [7:0] credit;
    logic [3:0] sold_out;

    int checks = 0;
    int passed = 0;
    logic [1:0] exp_vend [$];
    logic [1:0] exp_chg  [$];

    vending_machine_multi dut (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin(coin),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .restock(restock),
        .chg_ready(chg_ready), .vend_valid(vend_valid), .vend_id(vend_id),
        .chg_valid(chg_valid), .chg_coin(chg_coin), .coin_reject(coin_reject),
        .sel_nack(sel_nack), .credit(credit), .state(state), .sold_out(sold_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (vend_valid) begin
                checks++;
                if (exp_vend.size() == 0) begin
                    $display("FAIL vend_unexpected: got vend_id=%0d, required no vend", vend_id);
                end else begin
                    logic [1:0] e;
                    e = exp_vend.pop_front();
                    if (vend_id !== e) $display("FAIL vend_id: got %0d, required %0d", vend_id, e);
                    else passed++;
                end
            end
            if (chg_valid && chg_ready) begin
                checks++;
                if (exp_chg.size() == 0) begin
                    $display("FAIL chg_unexpected: got chg_coin=%b, required no coin", chg_coin);
                end else begin
                    logic [1:0] e;
                    e = exp_chg.pop_front();
                    if (chg_coin !== e) $display("FAIL chg_coin: got %b, required %b", chg_coin, e);
                    else passed++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin_valid = 1'b1;
        coin       = c;
        tick();
        coin_valid = 1'b0;
        coin       = 2'b00;
    endtask

    task automatic pick(input logic [1:0] s);
        sel_valid = 1'b1;
        sel       = s;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic drain(output int n);
        chg_ready = 1'b1;
        n = 0;
        while (state != 2'b00 && n < 40) begin
            tick();
            n++;
        end
        chg_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({state, credit} !== {2'b00, 8'd0})
            $display("FAIL reset_state_credit: got %b/%0d, required 00/0", state, credit);
        else passed++;
        checks++;
        if ({vend_valid, chg_valid, coin_reject, sel_nack, vend_id, chg_coin, sold_out} !== 12'd0)
            $display("FAIL reset_outputs: got %b%b%b%b %0d %b %b, required all zero",
                     vend_valid, chg_valid, coin_reject, sel_nack, vend_id, chg_coin, sold_out);
        else passed++;
    endtask

    task automatic test_exact_vend();
        do_reset();
        put_coin(2'b10);
        put_coin(2'b01);
        checks++;
        if ({state, credit} !== {2'b01, 8'd3})
            $display("FAIL exact_credit: got %b/%0d, required 01/3", state, credit);
        else passed++;
        exp_vend.push_back(2'd0);
        pick(2'd0);
        checks++;
        if ({state, vend_valid} !== {2'b10, 1'b1})
            $display("FAIL exact_vend_state: got %b/%b, required 10/1", state, vend_valid);
        else passed++;
        tick();
        checks++;
        if ({state, credit, chg_valid} !== {2'b00, 8'd0, 1'b0})
            $display("FAIL exact_after: got %b/%0d/%b, required 00/0/0", state, credit, chg_valid);
        else passed++;
    endtask

    task automatic test_change_stall();
        int n;
        do_reset();
        put_coin(2'b11);
        put_coin(2'b10);
        exp_vend.push_back(2'd2);
        pick(2'd2);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({state, chg_valid, chg_coin, credit} !== {2'b11, 1'b1, 2'b11, 8'd4})
                $display("FAIL stall_cycle%0d: got %b/%b/%b/%0d, required 11/1/11/4",
                         i, state, chg_valid, chg_coin, credit);
            else passed++;
            tick();
        end
        exp_chg.push_back(2'b11);
        drain(n);
        checks++;
        if ({n[7:0], state, credit} !== {8'd1, 2'b00, 8'd0})
            $display("FAIL stall_drain: got %0d cycles %b/%0d, required 1 cycle 00/0", n, state, credit);
        else passed++;
    endtask

    task automatic test_short_credit_cancel();
        int n;
        do_reset();
        put_coin(2'b10);
        pick(2'd3);
        checks++;
        if ({sel_nack, state, credit} !== {1'b1, 2'b01, 8'd2})
            $display("FAIL short_nack: got %b/%b/%0d, required 1/01/2", sel_nack, state, credit);
        else passed++;
        tick();
        checks++;
        if (sel_nack !== 1'b0) $display("FAIL nack_pulse: got %b, required 0", sel_nack);
        else passed++;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if ({state, chg_coin, credit} !== {2'b11, 2'b10, 8'd2})
            $display("FAIL cancel_change: got %b/%b/%0d, required 11/10/2", state, chg_coin, credit);
        else passed++;
        exp_chg.push_back(2'b10);
        drain(n);
        checks++;
        if ({n[7:0], state} !== {8'd1, 2'b00})
            $display("FAIL cancel_drain: got %0d cycles state %b, required 1 cycle 00", n, state);
        else passed++;
    endtask

    task automatic test_sold_out_restock();
        int n;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            put_coin(2'b10);
            exp_vend.push_back(2'd2);
            pick(2'd2);
            tick();
        end
        checks++;
        if ({sold_out, state, credit} !== {4'b0100, 2'b00, 8'd0})
            $display("FAIL sold_out: got %b/%b/%0d, required 0100/00/0", sold_out, state, credit);
        else passed++;
        put_coin(2'b10);
        pick(2'd2);
        checks++;
        if ({sel_nack, state, credit} !== {1'b1, 2'b01, 8'd2})
            $display("FAIL sold_out_nack: got %b/%b/%0d, required 1/01/2", sel_nack, state, credit);
        else passed++;
        restock = 1'b1;
        tick();
        restock = 1'b0;
        checks++;
        if (sold_out !== 4'b0000) $display("FAIL restock: got %b, required 0000", sold_out);
        else passed++;
        exp_vend.push_back(2'd2);
        pick(2'd2);
        tick();
        checks++;
        if ({sold_out, state} !== {4'b0000, 2'b00})
            $display("FAIL restock_vend: got %b/%b, required 0000/00", sold_out, state);
        else passed++;
    endtask

    task automatic test_credit_limit();
        int n;
        do_reset();
        for (int k = 0; k < 5; k++) put_coin(2'b11);
        checks++;
        if ({coin_reject, credit} !== {1'b0, 8'd20})
            $display("FAIL limit_exact: got %b/%0d, required 0/20", coin_reject, credit);
        else passed++;
        put_coin(2'b01);
        checks++;
        if ({coin_reject, credit} !== {1'b1, 8'd20})
            $display("FAIL limit_over5: got %b/%0d, required 1/20", coin_reject, credit);
        else passed++;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        for (int k = 0; k < 5; k++) exp_chg.push_back(2'b11);
        drain(n);
        checks++;
        if ({n[7:0], state, credit} !== {8'd5, 2'b00, 8'd0})
            $display("FAIL limit_drain: got %0d cycles %b/%0d, required 5 cycles 00/0", n, state, credit);
        else passed++;
        for (int k = 0; k < 4; k++) put_coin(2'b11);
        put_coin(2'b10);
        put_coin(2'b11);
        checks++;
        if ({coin_reject, credit} !== {1'b1, 8'd18})
            $display("FAIL limit_reject20: got %b/%0d, required 1/18", coin_reject, credit);
        else passed++;
        exp_vend.push_back(2'd0);
        coin_valid = 1'b1;
        coin       = 2'b01;
        pick(2'd0);
        coin_valid = 1'b0;
        coin       = 2'b00;
        checks++;
        if ({state, coin_reject, credit} !== {2'b10, 1'b1, 8'd18})
            $display("FAIL coin_with_sel: got %b/%b/%0d, required 10/1/18", state, coin_reject, credit);
        else passed++;
        tick();
        checks++;
        if ({state, credit} !== {2'b11, 8'd15})
            $display("FAIL vend_remainder: got %b/%0d, required 11/15", state, credit);
        else passed++;
        exp_chg.push_back(2'b11);
        exp_chg.push_back(2'b11);
        exp_chg.push_back(2'b11);
        exp_chg.push_back(2'b10);
        exp_chg.push_back(2'b01);
        drain(n);
        checks++;
        if ({n[7:0], state, credit} !== {8'd5, 2'b00, 8'd0})
            $display("FAIL remainder_drain: got %0d cycles %b/%0d, required 5 cycles 00/0", n, state, credit);
        else passed++;
    endtask

    task automatic test_priority();
        int n;
        do_reset();
        pick(2'd0);
        checks++;
        if ({sel_nack, state} !== {1'b1, 2'b00})
            $display("FAIL idle_nack: got %b/%b, required 1/00", sel_nack, state);
        else passed++;
        put_coin(2'b10);
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin       = 2'b01;
        pick(2'd2);
        cancel     = 1'b0;
        coin_valid = 1'b0;
        coin       = 2'b00;
        checks++;
        if ({state, coin_reject, sel_nack, credit} !== {2'b11, 1'b1, 1'b0, 8'd2})
            $display("FAIL cancel_priority: got %b/%b/%b/%0d, required 11/1/0/2",
                     state, coin_reject, sel_nack, credit);
        else passed++;
        exp_chg.push_back(2'b10);
        drain(n);
        checks++;
        if (state !== 2'b00) $display("FAIL priority_drain: got %b, required 00", state);
        else passed++;
    endtask

    task automatic test_reset_in_change();
        put_coin(2'b10);
        put_coin(2'b01);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if ({state, credit, chg_valid} !== {2'b11, 8'd3, 1'b1})
            $display("FAIL pre_reset_change: got %b/%0d/%b, required 11/3/1", state, credit, chg_valid);
        else passed++;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({state, credit, chg_valid, chg_coin} !== {2'b00, 8'd0, 1'b0, 2'b00})
            $display("FAIL reset_in_change: got %b/%0d/%b/%b, required 00/0/0/00",
                     state, credit, chg_valid, chg_coin);
        else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; coin_valid = 1'b0; coin = 2'b00; sel_valid = 1'b0; sel = 2'd0;
        cancel = 1'b0; restock = 1'b0; chg_ready = 1'b0;
        test_reset();
        test_exact_vend();
        test_change_stall();
        test_short_credit_cancel();
        test_sold_out_restock();
        test_credit_limit();
        test_priority();
        test_reset_in_change();
        checks++;
        if (exp_vend.size() != 0 || exp_chg.size() != 0)
            $display("FAIL leftover_expected: got %0d vends and %0d coins outstanding, required 0/0",
                     exp_vend.size(), exp_chg.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
